// File: rtl/param_micro_core_pkg.sv
// Shared ISA definitions for param_micro_core: opcode values, instruction layout and FSM states.
package param_micro_core_pkg;

  localparam int OPCODE_W = 8;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_FETCH,
    ST_EXEC,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_HALT = 8'h00;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 8'h01;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 8'h02;
  localparam logic [OPCODE_W-1:0] OP_MOV  = 8'h03;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 8'h04;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 8'h05;
  localparam logic [OPCODE_W-1:0] OP_CLR  = 8'h06;
  localparam logic [OPCODE_W-1:0] OP_DEC  = 8'h07;
  localparam logic [OPCODE_W-1:0] OP_JNZ  = 8'h08;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 8'h09;

endpackage

// File: rtl/param_micro_core_prog_mem.sv
// Program store for param_micro_core: one write port for loading, one registered read port for fetch.
module param_micro_core_prog_mem #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/param_micro_core.sv
// Parametrised micro core: loads a program word by word, then runs it against a data memory
// with a debug read port, sticky done/error flags and a run-time watchdog.
module param_micro_core
  import param_micro_core_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int FIELD_W    = 8,
  parameter int MEM_DEPTH  = 128,
  parameter int PROG_DEPTH = 64,
  parameter int MAX_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [OPCODE_W+2*FIELD_W-1:0]  instr_in,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [$clog2(MEM_DEPTH)-1:0]   select_mem,
  output logic [DATA_W-1:0]              output_mem_cell,
  output logic                           program_done_flag,
  output logic                           error_flag,
  output logic [$clog2(PROG_DEPTH)-1:0]  pc_out
);

  localparam int IW = OPCODE_W + 2 * FIELD_W;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(PROG_DEPTH);
  localparam int JW = PW + 1;
  localparam int CW = $clog2(MAX_CYCLES);

  state_t            state;
  logic [JW-1:0]     load_ptr;
  logic [PW-1:0]     pc;
  logic [CW-1:0]     cycle_cnt;
  logic [DATA_W-1:0] dmem [MEM_DEPTH];
  logic [IW-1:0]     ir;

  logic              prog_wr;
  logic              prog_rd;
  logic              load_last;

  logic [OPCODE_W-1:0] opcode;
  logic [FIELD_W-1:0]  field_a;
  logic [FIELD_W-1:0]  field_b;
  logic [AW-1:0]       addr_a;
  logic [AW-1:0]       addr_b;
  logic [DATA_W-1:0]   val_a;
  logic [DATA_W-1:0]   val_b;

  logic [JW-1:0]     pc_seq;
  logic [JW-1:0]     jump_off;
  logic [JW-1:0]     jump_target;

  logic              exec_wr;
  logic [DATA_W-1:0] exec_data;
  logic              exec_halt;
  logic              exec_illegal;
  logic              exec_jump;
  logic [JW-1:0]     exec_target;
  logic              exec_oor;
  logic              exec_fault;
  logic              exec_fall;
  logic              watchdog_hit;

  assign prog_wr   = (state == ST_LOAD) && instr_valid;
  assign prog_rd   = (state == ST_FETCH);
  assign load_last = (instr_in[IW-1 -: OPCODE_W] == OP_HALT) ||
                     (load_ptr == JW'(PROG_DEPTH - 1));

  param_micro_core_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (IW)
  ) u_prog_mem (
    .clk     (clk),
    .wr_en   (prog_wr),
    .wr_addr (load_ptr[PW-1:0]),
    .wr_data (instr_in),
    .rd_en   (prog_rd),
    .rd_addr (pc),
    .rd_data (ir)
  );

  assign opcode  = ir[IW-1 -: OPCODE_W];
  assign field_a = ir[2*FIELD_W-1 -: FIELD_W];
  assign field_b = ir[FIELD_W-1:0];
  assign addr_a  = field_a[AW-1:0];
  assign addr_b  = field_b[AW-1:0];
  assign val_a   = dmem[addr_a];
  assign val_b   = dmem[addr_b];

  // Jumps are resolved in PW+1 bits so a negative target shows up as a value >= load_ptr.
  assign pc_seq      = {1'b0, pc} + JW'(1);
  assign jump_off    = JW'(signed'(field_a));
  assign jump_target = {1'b0, pc} + jump_off;

  always_comb begin
    exec_wr      = 1'b0;
    exec_data    = '0;
    exec_halt    = 1'b0;
    exec_illegal = 1'b0;
    exec_jump    = 1'b0;
    exec_target  = pc_seq;
    case (opcode)
      OP_HALT: exec_halt = 1'b1;
      OP_NOP:  exec_wr   = 1'b0;
      OP_LDI: begin
        exec_wr   = 1'b1;
        exec_data = DATA_W'(field_b);
      end
      OP_MOV: begin
        exec_wr   = 1'b1;
        exec_data = val_b;
      end
      OP_ADD: begin
        exec_wr   = 1'b1;
        exec_data = val_a + val_b;
      end
      OP_SUB: begin
        exec_wr   = 1'b1;
        exec_data = val_a - val_b;
      end
      OP_CLR: begin
        exec_wr   = 1'b1;
        exec_data = '0;
      end
      OP_DEC: begin
        exec_wr   = 1'b1;
        exec_data = val_a - DATA_W'(1);
      end
      OP_JNZ: begin
        if (val_b != '0) begin
          exec_jump   = 1'b1;
          exec_target = jump_target;
        end
      end
      OP_JMP: begin
        exec_jump   = 1'b1;
        exec_target = jump_target;
      end
      default: exec_illegal = 1'b1;
    endcase
  end

  assign exec_oor     = (exec_target >= load_ptr);
  assign exec_fault   = exec_illegal || (exec_jump && exec_oor);
  assign exec_fall    = !exec_jump && exec_oor;
  assign watchdog_hit = (cycle_cnt == CW'(MAX_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= ST_LOAD;
      load_ptr          <= '0;
      pc                <= '0;
      cycle_cnt         <= '0;
      program_done_flag <= 1'b0;
      error_flag        <= 1'b0;
      output_mem_cell   <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        dmem[i] <= '0;
      end
    end else begin
      output_mem_cell <= dmem[select_mem];
      case (state)
        ST_LOAD: begin
          if (instr_valid) begin
            load_ptr <= load_ptr + JW'(1);
            if (load_last) begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH, ST_EXEC: begin
          // The watchdog outranks whatever the current instruction would commit.
          if (watchdog_hit) begin
            state      <= ST_ERROR;
            error_flag <= 1'b1;
          end else begin
            cycle_cnt <= cycle_cnt + CW'(1);
            if (state == ST_FETCH) begin
              state <= ST_EXEC;
            end else if (exec_fault) begin
              state      <= ST_ERROR;
              error_flag <= 1'b1;
            end else if (exec_halt) begin
              state             <= ST_DONE;
              program_done_flag <= 1'b1;
            end else begin
              if (exec_wr) begin
                dmem[addr_a] <= exec_data;
              end
              if (exec_fall) begin
                state             <= ST_DONE;
                program_done_flag <= 1'b1;
              end else begin
                pc    <= exec_target[PW-1:0];
                state <= ST_FETCH;
              end
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign instr_ready = (state == ST_LOAD);
  assign pc_out      = pc;

endmodule
